prbs_decim_ber: RTL and testbench

- Downstream consumer of the FIR pulse-shaping filter output stream (signed oversampled samples, OS_FACTOR samples per symbol).
- Decimates by OS_FACTOR at a programmable sampling phase and slices each kept sample to a bit.
- Self-synchronises a local PRBS9 reference to the bit stream, then counts compared bits and bit errors for BER measurement.

---
 rtl/prbs_decim_ber.sv | 169 ++++++++++++++++
 tb/tb_prbs_decim_ber.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_decim_ber.sv
// Decimating slicer with self-synchronising PRBS9 bit-error-rate counter.
// Keeps one sample per symbol at a programmable phase, slices it, and counts errors once locked.
module prbs_decim_ber #(
    parameter int unsigned WW_INPUT  = 8,
    parameter int unsigned OS_FACTOR = 4,
    parameter int unsigned WW_PHASE  = 2,
    parameter int unsigned WW_CNT    = 32,
    parameter int unsigned WIN_LEN   = 1023,
    parameter int unsigned ERR_THR   = 0
) (
    input  logic                clk,
    input  logic                i_srst,
    input  logic                i_en,
    input  logic [WW_PHASE-1:0] i_phase,
    input  logic [WW_INPUT-1:0] i_data,
    output logic                o_bit,
    output logic                o_bit_valid,
    output logic                o_lock,
    output logic [WW_CNT-1:0]   o_bit_count,
    output logic [WW_CNT-1:0]   o_err_count
);

    localparam int unsigned WW_WIN   = $clog2(WIN_LEN + 1);
    localparam int unsigned WW_LOAD  = 4;
    localparam int unsigned PRBS_LEN = 9;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    logic [WW_PHASE-1:0] phase_q, phase_d;
    logic                bit_q, bit_d;
    logic                bit_valid_q, bit_valid_d;
    logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
    state_e              state_q, state_d;
    logic [WW_LOAD-1:0]  load_cnt_q, load_cnt_d;
    logic [WW_WIN-1:0]   win_cnt_q, win_cnt_d;
    logic [WW_WIN-1:0]   win_err_q, win_err_d;
    logic                lock_q, lock_d;
    logic [WW_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WW_CNT-1:0]   err_cnt_q, err_cnt_d;

    logic                exp_bit;
    logic                mismatch;
    logic [WW_WIN-1:0]   win_err_inc;
    logic                win_end;
    logic                win_pass;
    logic                slice_bit;

    // Signed compare reduces to the sign bit: zero and positive slice to 0.
    assign slice_bit = ($signed(i_data) < $signed(WW_INPUT'(0)));

    // Phase counter and decimating slicer.
    always_comb begin
        phase_d     = phase_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        if (i_en) begin
            phase_d = (phase_q == WW_PHASE'(OS_FACTOR - 1)) ? '0 : phase_q + 1'b1;
            if (phase_q == i_phase) begin
                bit_d       = slice_bit;
                bit_valid_d = 1'b1;
            end
        end
    end

    assign exp_bit     = lfsr_q[8] ^ lfsr_q[4];
    assign mismatch    = bit_q ^ exp_bit;
    assign win_err_inc = win_err_q + WW_WIN'(mismatch);
    assign win_end     = (win_cnt_q == WW_WIN'(WIN_LEN - 1));
    assign win_pass    = (32'(win_err_inc) <= ERR_THR);

    // Synchronisation FSM, reference LFSR and BER counters; all advance on decisions only.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        load_cnt_d = load_cnt_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (bit_valid_q) begin
            case (state_q)
                ST_LOAD: begin
                    lfsr_d = {lfsr_q[PRBS_LEN-2:0], bit_q};
                    if (load_cnt_q == WW_LOAD'(PRBS_LEN - 1)) begin
                        state_d    = ST_CHECK;
                        load_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    lfsr_d = {lfsr_q[PRBS_LEN-2:0], exp_bit};
                    if (win_end) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        state_d   = win_pass ? ST_LOCKED : ST_LOAD;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_inc;
                    end
                end
                ST_LOCKED: begin
                    lfsr_d = {lfsr_q[PRBS_LEN-2:0], exp_bit};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (mismatch && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (win_end) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (!win_pass) begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_inc;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
        lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            phase_q     <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            lfsr_q      <= 9'h1FF;
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            lock_q      <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            lfsr_q      <= lfsr_d;
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            lock_q      <= lock_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_lock      = lock_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_decim_ber.sv
// Scoreboard bench for prbs_decim_ber: PRBS9 symbol stream in, decisions and BER counters checked.
// A second instance with 4-bit counters exercises counter saturation.
module tb_prbs_decim_ber;

    localparam int unsigned WW_INPUT = 8;
    localparam int unsigned WW_PHASE = 2;
    localparam int unsigned WW_CNT   = 32;
    localparam int unsigned WW_SAT   = 4;
    localparam int unsigned SAT_MAX  = 15;

    logic                clk = 1'b0;
    logic                i_srst;
    logic                i_en;
    logic [WW_PHASE-1:0] i_phase;
    logic [WW_INPUT-1:0] i_data;
    logic                o_bit, o_bit_valid, o_lock;
    logic [WW_CNT-1:0]   o_bit_count, o_err_count;
    logic                s_bit, s_bit_valid, s_lock;
    logic [WW_SAT-1:0]   s_bit_count, s_err_count;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic [8:0] gen_q;
    int   tb_ph;
    logic distinct;
    logic gapped;
    logic zero_map;

    always #5 clk = ~clk;

    prbs_decim_ber u_dut (
        .clk(clk), .i_srst(i_srst), .i_en(i_en), .i_phase(i_phase), .i_data(i_data),
        .o_bit(o_bit), .o_bit_valid(o_bit_valid), .o_lock(o_lock),
        .o_bit_count(o_bit_count), .o_err_count(o_err_count)
    );

    prbs_decim_ber #(.WW_CNT(WW_SAT)) u_sat (
        .clk(clk), .i_srst(i_srst), .i_en(i_en), .i_phase(i_phase), .i_data(i_data),
        .o_bit(s_bit), .o_bit_valid(s_bit_valid), .o_lock(s_lock),
        .o_bit_count(s_bit_count), .o_err_count(s_err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every decision strobe pops the expected bit pushed at stimulus time.
    always @(posedge clk) begin
        logic e;
        #1;
        if (o_bit_valid === 1'b1 || s_bit_valid === 1'b1) begin
            check("valid", 32'(o_bit_valid), 32'(1));
            check("valid_sat", 32'(s_bit_valid), 32'(1));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bit actual=strobe required=no_strobe");
            end else begin
                e = exp_q.pop_front();
                check("bit", 32'(o_bit), 32'(e));
                check("bit_sat", 32'(s_bit), 32'(e));
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] enc(input logic b, input int mag);
        if (b) return 8'(-mag);
        if (zero_map) return 8'd0;
        return 8'(mag);
    endfunction

    task automatic drive_sample(input logic en, input logic [7:0] d, input logic expbit);
        @(negedge clk);
        i_en   = en;
        i_data = d;
        if (en) begin
            if (tb_ph == int'(i_phase)) exp_q.push_back(expbit);
            tb_ph = (tb_ph + 1) % 4;
        end
    endtask

    // One symbol of four samples; in distinct mode only the selected phase carries the true sign.
    task automatic send_sym(input logic b);
        int   mag;
        logic bb;
        for (int j = 0; j < 4; j++) begin
            mag = distinct ? ((j == int'(i_phase)) ? 40 + j : 10 + j) : 64;
            bb  = (distinct && j != int'(i_phase)) ? ~b : b;
            if (gapped) begin
                drive_sample(1'b0, 8'h55, 1'b0);
                drive_sample(1'b0, 8'hAA, 1'b0);
            end
            drive_sample(1'b1, enc(bb, mag), b);
        end
    endtask

    task automatic send_prbs(input int n, input int inject_every);
        logic b;
        for (int k = 0; k < n; k++) begin
            b     = gen_q[8] ^ gen_q[4];
            gen_q = {gen_q[7:0], b};
            if (inject_every > 0 && (k % inject_every) == inject_every - 1) b = ~b;
            send_sym(b);
        end
    endtask

    task automatic settle();
        repeat (3) drive_sample(1'b0, 8'h00, 1'b0);
        check("sb_drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic expect_state(input string tag, input logic lock, input int bits, input int errs);
        check({tag, "_lock"}, 32'(o_lock), 32'(lock));
        check({tag, "_lock_sat"}, 32'(s_lock), 32'(lock));
        check({tag, "_bits"}, o_bit_count, 32'(bits));
        check({tag, "_errs"}, o_err_count, 32'(errs));
        check({tag, "_bits_sat"}, 32'(s_bit_count), (bits > int'(SAT_MAX)) ? SAT_MAX : 32'(bits));
        check({tag, "_errs_sat"}, 32'(s_err_count), (errs > int'(SAT_MAX)) ? SAT_MAX : 32'(errs));
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_srst = 1'b1;
        i_en   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_bit", 32'(o_bit), 32'(0));
        check("rst_valid", 32'(o_bit_valid), 32'(0));
        expect_state("rst", 1'b0, 0, 0);
        @(negedge clk);
        i_srst = 1'b0;
        tb_ph  = 0;
        exp_q.delete();
    endtask

    // Lock must appear exactly on the 1032nd decision after reset.
    task automatic lock_after_reset(input string tag);
        send_prbs(1031, 0);
        settle();
        check({tag, "_prelock"}, 32'(o_lock), 32'(0));
        send_prbs(1, 0);
        settle();
        expect_state({tag, "_lock"}, 1'b1, 0, 0);
        send_prbs(10, 0);
        settle();
        expect_state({tag, "_run"}, 1'b1, 10, 0);
    endtask

    initial begin
        i_srst   = 1'b0;
        i_en     = 1'b0;
        i_phase  = '0;
        i_data   = '0;
        gen_q    = 9'h1FF;
        tb_ph    = 0;
        distinct = 1'b0;
        gapped   = 1'b0;
        zero_map = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Ideal stream, phase 0, continuous enable.
        send_prbs(1031, 0);
        settle();
        check("t1_prelock", 32'(o_lock), 32'(0));
        send_prbs(1, 0);
        settle();
        expect_state("t1_lock", 1'b1, 0, 0);
        send_prbs(4000, 0);
        settle();
        expect_state("t1_run", 1'b1, 4000, 0);

        // One inverted symbol per 100; window ends 92 decisions in, then at 1115.
        send_prbs(300, 100);
        settle();
        expect_state("err_inj", 1'b1, 4300, 3);
        send_prbs(814, 0);
        settle();
        expect_state("err_hold", 1'b1, 5114, 3);
        send_prbs(1, 0);
        settle();
        expect_state("err_drop", 1'b0, 5115, 3);
        send_prbs(1031, 0);
        settle();
        expect_state("err_prelock", 1'b0, 5115, 3);
        send_prbs(1, 0);
        settle();
        expect_state("err_relock", 1'b1, 5115, 3);
        send_prbs(100, 0);
        settle();
        expect_state("err_resume", 1'b1, 5215, 3);

        // Reset while locked; zero-valued samples must slice to 0.
        do_reset();
        zero_map = 1'b1;
        lock_after_reset("zero");
        zero_map = 1'b0;

        // Phase sweep with only the selected sample carrying the true sign.
        distinct = 1'b1;
        for (int p = 1; p < 4; p++) begin
            i_phase = WW_PHASE'(p);
            do_reset();
            lock_after_reset($sformatf("ph%0d", p));
        end
        distinct = 1'b0;

        // Enable asserted one cycle in three.
        i_phase = 2'd2;
        gapped  = 1'b1;
        do_reset();
        lock_after_reset("gap");
        gapped = 1'b0;

        // Non-PRBS data never locks.
        i_phase = 2'd0;
        do_reset();
        for (int k = 0; k < 1500; k++) send_sym(1'($urandom_range(0, 1)));
        settle();
        expect_state("rand", 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
